// File: rtl/spsram_fifo_ctrl_if.sv
// Push/pop stream and single-port SRAM bus bundle for spsram_fifo_ctrl.
// master = the controller's view, slave = the environment (producer, consumer, SRAM).
interface spsram_fifo_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          i_push_valid;
  logic [DW-1:0] i_push_data;
  logic          o_push_ready;
  logic          o_pop_valid;
  logic [DW-1:0] o_pop_data;
  logic          i_pop_ready;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_wen;
  logic          o_mem_cen;
  logic          o_mem_oen;
  logic [DW-1:0] i_mem_data;

  modport master (
    input  i_push_valid, i_push_data, i_pop_ready, i_mem_data,
    output o_push_ready, o_pop_valid, o_pop_data,
    output o_mem_addr, o_mem_data, o_mem_wen, o_mem_cen, o_mem_oen
  );

  modport slave (
    output i_push_valid, i_push_data, i_pop_ready, i_mem_data,
    input  o_push_ready, o_pop_valid, o_pop_data,
    input  o_mem_addr, o_mem_data, o_mem_wen, o_mem_cen, o_mem_oen
  );
endinterface

// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM: one access per cycle, reads win the port.
// Define SPSRAM_FIFO_ASYNC_RD_EN for an asynchronous-read SRAM (1 pop/cycle, no in-flight stage).
module spsram_fifo_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  spsram_fifo_ctrl_if.master   bus,
  output logic [AW+1:0]        o_count,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam int DEPTH = 2**AW;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          rd_inflight;
  logic          pop_valid_q;
  logic [DW-1:0] pop_data_q;
  logic          pop_fire;
  logic          rd_req;
  logic          push_fire;
  logic          load_out;
  logic          mem_has_data;
  logic          mem_full;

  assign mem_has_data = (mem_cnt != '0);
  assign mem_full     = (mem_cnt == (AW+1)'(DEPTH));
  assign pop_fire     = pop_valid_q & bus.i_pop_ready;

`ifdef SPSRAM_FIFO_ASYNC_RD_EN
  assign rd_inflight = 1'b0;
  assign rd_req      = mem_has_data & (!pop_valid_q | pop_fire);
  assign load_out    = rd_req;
`else
  assign rd_req      = mem_has_data & !rd_inflight & (!pop_valid_q | pop_fire);
  assign load_out    = rd_inflight;

  // The SRAM returns read data one cycle after the request.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) rd_inflight <= 1'b0;
    else         rd_inflight <= rd_req;
  end
`endif

  assign bus.o_push_ready = !mem_full & !rd_req;
  assign push_fire        = bus.i_push_valid & bus.o_push_ready;

  always_comb begin
    bus.o_mem_addr = '0;
    bus.o_mem_cen  = 1'b0;
    bus.o_mem_wen  = 1'b0;
    bus.o_mem_oen  = 1'b0;
    if (rd_req) begin
      bus.o_mem_addr = rd_ptr;
      bus.o_mem_cen  = 1'b1;
      bus.o_mem_oen  = 1'b1;
    end else if (push_fire) begin
      bus.o_mem_addr = wr_ptr;
      bus.o_mem_cen  = 1'b1;
      bus.o_mem_wen  = 1'b1;
    end
  end

  assign bus.o_mem_data = bus.i_push_data;

  // push_fire and rd_req are mutually exclusive, so mem_cnt moves by at most one.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr  <= wr_ptr + AW'(1);
        mem_cnt <= mem_cnt + (AW+1)'(1);
      end else if (rd_req) begin
        rd_ptr  <= rd_ptr + AW'(1);
        mem_cnt <= mem_cnt - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else if (load_out) begin
      pop_valid_q <= 1'b1;
      pop_data_q  <= bus.i_mem_data;
    end else if (pop_fire) begin
      pop_valid_q <= 1'b0;
    end
  end

  assign bus.o_pop_valid = pop_valid_q;
  assign bus.o_pop_data  = pop_data_q;

  assign o_count = (AW+2)'(mem_cnt) + (AW+2)'(rd_inflight) + (AW+2)'(pop_valid_q);
  assign o_full  = mem_full;
  assign o_empty = (o_count == '0);
endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// Self-checking bench for spsram_fifo_ctrl with a behavioural 32x32 single-port SRAM.
// The SRAM model follows SPSRAM_FIFO_ASYNC_RD_EN the same way the controller does.
module tb_spsram_fifo_ctrl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic [6:0]  count;
  logic        full;
  logic        empty;
  logic [31:0] sram [32];
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        pop_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [6:0]  exp_count;
    logic        exp_push_ready;
    logic        exp_oen;
  } vec_t;

  vec_t tbl[$];

  spsram_fifo_ctrl_if #(.DW(32), .AW(5)) bus ();

  spsram_fifo_ctrl #(.DW(32), .AW(5)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .bus     (bus),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_mem_cen && bus.o_mem_wen) sram[bus.o_mem_addr] <= bus.o_mem_data;
    if (bus.o_mem_cen && bus.o_mem_oen) rdata <= sram[bus.o_mem_addr];
  end

`ifdef SPSRAM_FIFO_ASYNC_RD_EN
  assign bus.i_mem_data = sram[bus.o_mem_addr];
`else
  assign bus.i_mem_data = rdata;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pd, input logic pr);
    bus.i_push_valid = pv;
    bus.i_push_data  = pd;
    bus.i_pop_ready  = pr;
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Offer n consecutive words base, base+1, ... with the consumer stalled.
  task automatic pushWords(input int n, input logic [31:0] base, input int budget, output int sent);
    logic fire;
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, base + 32'(sent), 1'b0);
      fire = bus.o_push_ready;
      @(posedge clk);
      if (fire) sent++;
    end
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  initial begin
    int sent;
    int pushed;
    int popped;
    int max_cnt;
    bit pf;
    bit popf;
    bit got;
    logic [31:0] q[$];

    bus.i_push_valid = 1'b0;
    bus.i_push_data  = '0;
    bus.i_pop_ready  = 1'b0;
    doReset();

    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_push_ready", 32'(bus.o_push_ready), 32'd1);
    checkOutput("rst_empty",      32'(empty),            32'd1);
    checkOutput("rst_full",       32'(full),             32'd0);
    checkOutput("rst_count",      32'(count),            32'd0);
    checkOutput("rst_pop_valid",  32'(bus.o_pop_valid),  32'd0);

    // Fill: 32 words in SRAM plus word 0 in the output register.
    pushWords(40, 32'd0, 60, sent);
    checkOutput("fill_accepted",   32'(sent),             32'd33);
    checkOutput("fill_full",       32'(full),             32'd1);
    checkOutput("fill_count",      32'(count),            32'd33);
    checkOutput("fill_push_ready", 32'(bus.o_push_ready), 32'd0);
    checkOutput("fill_pop_valid",  32'(bus.o_pop_valid),  32'd1);
    checkOutput("fill_pop_data",   bus.o_pop_data,        32'd0);

`ifdef SPSRAM_FIFO_ASYNC_RD_EN
    for (int k = 0; k <= 32; k++)
      tbl.push_back('{1'b1, 1'b1, 32'(k), 7'(33 - k), (k == 32), (k < 32)});
    tbl.push_back('{1'b1, 1'b0, 32'd32, 7'd0, 1'b1, 1'b0});
`else
    for (int k = 0; k <= 32; k++) begin
      tbl.push_back('{1'b1, 1'b1, 32'(k), 7'(33 - k), (k == 32), (k < 32)});
      tbl.push_back('{1'b1, 1'b0, 32'(k), 7'(32 - k), 1'b1, 1'b0});
    end
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, tbl[i].pop_ready);
      checkOutput($sformatf("drain%0d_valid", i), 32'(bus.o_pop_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        checkOutput($sformatf("drain%0d_data", i), bus.o_pop_data, tbl[i].exp_data);
      checkOutput($sformatf("drain%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      checkOutput($sformatf("drain%0d_push_ready", i), 32'(bus.o_push_ready), 32'(tbl[i].exp_push_ready));
      checkOutput($sformatf("drain%0d_oen", i), 32'(bus.o_mem_oen), 32'(tbl[i].exp_oen));
    end
    idle(1);
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Random valid/ready traffic across the pointer wrap.
    pushed = 0;
    popped = 0;
    max_cnt = 0;
    for (int c = 0; c < 5000 && popped < 100; c++) begin
      @(negedge clk);
      applyStimulus((pushed < 100) && ($urandom_range(0, 1) == 1),
                    32'(pushed) ^ 32'hA5A5_0000,
                    $urandom_range(0, 1) == 1);
      pf   = bus.i_push_valid && bus.o_push_ready;
      popf = bus.o_pop_valid && bus.i_pop_ready;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (popf) begin
        if (q.size() == 0) checkOutput("rand_pop_underflow", 32'd1, 32'd0);
        else checkOutput($sformatf("rand_pop%0d", popped), bus.o_pop_data, q[0]);
      end
      @(posedge clk);
      if (pf) begin
        q.push_back(bus.i_push_data);
        pushed++;
      end
      if (popf) begin
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
    end
    idle(1);
    checkOutput("rand_popped", 32'(popped), 32'd100);
    checkOutput("rand_max_count_ok", 32'(max_cnt <= 33), 32'd1);
    checkOutput("rand_empty", 32'(empty), 32'd1);

    // A pending push loses the port to a read, then lands at wr_ptr 3 next cycle.
    doReset();
    pushWords(3, 32'h0000_0A00, 20, sent);
    checkOutput("prio_setup", 32'(sent), 32'd3);
    idle(3);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_BEEF, 1'b1);
    checkOutput("prio_rd_oen",        32'(bus.o_mem_oen),    32'd1);
    checkOutput("prio_rd_wen",        32'(bus.o_mem_wen),    32'd0);
    checkOutput("prio_rd_push_ready", 32'(bus.o_push_ready), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_BEEF, 1'b0);
    checkOutput("prio_wr_wen",        32'(bus.o_mem_wen),    32'd1);
    checkOutput("prio_wr_push_ready", 32'(bus.o_push_ready), 32'd1);
    checkOutput("prio_wr_addr",       32'(bus.o_mem_addr),   32'd3);
    idle(1);

`ifndef SPSRAM_FIFO_ASYNC_RD_EN
    // Reset while a read is in flight discards everything held.
    doReset();
    pushWords(5, 32'h0000_0500, 30, sent);
    checkOutput("rstmid_setup", 32'(sent), 32'd5);
    idle(3);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rstmid_rd_oen", 32'(bus.o_mem_oen), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rstmid_inflight_count", 32'(count), 32'd4);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rstmid_pop_valid", 32'(bus.o_pop_valid), 32'd0);
    checkOutput("rstmid_count",     32'(count),           32'd0);
    checkOutput("rstmid_empty",     32'(empty),           32'd1);
    pushWords(1, 32'h0000_1234, 10, sent);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1);
      if (bus.o_pop_valid) begin
        got = 1'b1;
        checkOutput("rstmid_pop_data", bus.o_pop_data, 32'h0000_1234);
      end
    end
    checkOutput("rstmid_pop_seen", 32'(got), 32'd1);
    idle(1);
`else
    // Asynchronous-read SRAM: ten stored words leave on ten consecutive cycles.
    doReset();
    pushWords(10, 32'h0000_0100, 40, sent);
    checkOutput("async_setup", 32'(sent), 32'd10);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("async_pop%0d_valid", i), 32'(bus.o_pop_valid), 32'd1);
      checkOutput($sformatf("async_pop%0d_data", i), bus.o_pop_data, 32'h0000_0100 + 32'(i));
    end
    idle(1);
    checkOutput("async_empty", 32'(empty), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
